// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter family.
package counter_pkg;

    localparam int   MODE_WRAP = 0;
    localparam int   MODE_SAT  = 1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

    // Limits a parallel-load value to the configured upper count limit.
    function automatic int unsigned clamp_load(input int unsigned val, input int unsigned max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: enable, sync clear/load, wrap or saturate at the
// limits, combinational limit flags and a registered terminal-count pulse.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP,
    parameter int RST_VAL  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc
);

    localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_C = WIDTH'(RST_VAL);
    localparam bit               SAT   = (SATURATE == MODE_SAT);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be >= 2");
    end
    if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL out of range 1..2**WIDTH-1");
    end
    if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
        $error("updown_counter_param: RST_VAL out of range 0..MAX_VAL");
    end
    if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_mode
        $error("updown_counter_param: SATURATE must be 0 or 1");
    end

    // Value taken when a step crosses a limit: wrap to the opposite end, or hold.
    function automatic logic [WIDTH-1:0] limit_step(input logic [WIDTH-1:0] raw,
                                                     input logic             crossed,
                                                     input logic             up);
        if (!crossed)
            return raw;
        if (SAT)
            return up ? MAX_C : '0;
        return up ? '0 : MAX_C;
    endfunction

    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   inc_x;
    logic [WIDTH:0]   dec_x;
    logic             over;
    logic             under;
    logic [WIDTH-1:0] load_c;

    // One extra bit exposes the carry past MAX_VAL and the borrow below zero.
    assign cnt_x  = {1'b0, count};
    assign inc_x  = cnt_x + 1'b1;
    assign dec_x  = cnt_x - 1'b1;
    assign over   = (inc_x > MAX_X);
    assign under  = dec_x[WIDTH];
    assign load_c = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= RST_C;
            tc    <= 1'b0;
        end else if (clear) begin
            count <= RST_C;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_c;
            tc    <= 1'b0;
        end else if (en) begin
            if (dir == DIR_UP) begin
                count <= limit_step(inc_x[WIDTH-1:0], over, 1'b1);
                tc    <= over;
            end else begin
                count <= limit_step(dec_x[WIDTH-1:0], under, 1'b0);
                tc    <= under;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    assign at_max = (count == MAX_C);
    assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations driven in lock-step.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, dir = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] cnt_a, cnt_b, cnt_c;
    logic       max_a, max_b, max_c, min_a, min_b, min_c, tc_a, tc_b, tc_c;

    int errors = 0;
    int checks = 0;

    // a: wrap, limit 15; b: saturate, limit 9; c: wrap, limit 9, reset value 3
    updown_counter_param #(.WIDTH(4), .MAX_VAL(15), .SATURATE(0), .RST_VAL(0)) dut_a (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt_a), .at_max(max_a), .at_min(min_a), .tc(tc_a));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RST_VAL(0)) dut_b (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt_b), .at_max(max_b), .at_min(min_b), .tc(tc_b));
    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RST_VAL(3)) dut_c (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt_c), .at_max(max_c), .at_min(min_c), .tc(tc_c));

    always #5 clk = ~clk;

    localparam int MMAX [3] = '{15, 9, 9};
    localparam int MSAT [3] = '{0, 1, 0};
    localparam int MRST [3] = '{0, 0, 3};
    int mc  [3];
    int mtc [3];

    function automatic int dut_cnt(input int i);
        case (i)
            0:       return int'(cnt_a);
            1:       return int'(cnt_b);
            default: return int'(cnt_c);
        endcase
    endfunction

    function automatic logic [2:0] dut_flags(input int i);
        case (i)
            0:       return {tc_a, max_a, min_a};
            1:       return {tc_b, max_b, min_b};
            default: return {tc_c, max_c, min_c};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i]  = MRST[i];
            mtc[i] = 0;
        end
    endtask

    // Reference behaviour per clock edge, using modular arithmetic on integers.
    task automatic model_edge();
        if (!reset) return;
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                mc[i] = MRST[i]; mtc[i] = 0;
            end else if (load) begin
                mc[i] = (int'(load_val) > MMAX[i]) ? MMAX[i] : int'(load_val); mtc[i] = 0;
            end else if (en && dir) begin
                mtc[i] = (mc[i] == MMAX[i]) ? 1 : 0;
                if (!(MSAT[i] == 1 && mc[i] == MMAX[i])) mc[i] = (mc[i] + 1) % (MMAX[i] + 1);
            end else if (en) begin
                mtc[i] = (mc[i] == 0) ? 1 : 0;
                if (!(MSAT[i] == 1 && mc[i] == 0)) mc[i] = (mc[i] + MMAX[i]) % (MMAX[i] + 1);
            end else begin
                mtc[i] = 0;
            end
        end
    endtask

    task automatic tick(input logic r, input logic e, input logic d, input logic c,
                        input logic l, input logic [3:0] lv);
        @(negedge clk);
        reset = r; en = e; dir = d; clear = c; load = l; load_val = lv;
        if (!r) model_reset();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) tick(1, 1, 1, 0, 0, 0);
        checks++;
        if (cnt_a !== 4'd7) begin errors++; $display("FAIL reset_precount got=%0d exp=7", cnt_a); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (cnt_a !== 4'd0 || tc_a !== 1'b0) begin
            errors++; $display("FAIL reset_async got=%0d/%b exp=0/0", cnt_a, tc_a);
        end
        checks++;
        if (cnt_c !== 4'd3) begin errors++; $display("FAIL reset_async_rstval got=%0d exp=3", cnt_c); end
        for (int k = 1; k <= 3; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            checks++;
            if (cnt_a !== 4'(k)) begin errors++; $display("FAIL reset_release got=%0d exp=%0d", cnt_a, k); end
        end
    endtask

    task automatic test_wrap();
        tick(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            checks++;
            if (cnt_a !== 4'(k % 16) || tc_a !== (k == 16) || max_a !== (k == 15) || min_a !== (k == 16)) begin
                errors++;
                $display("FAIL wrap_up step=%0d got cnt=%0d tc=%b max=%b min=%b exp cnt=%0d tc=%b max=%b min=%b",
                         k, cnt_a, tc_a, max_a, min_a, k % 16, k == 16, k == 15, k == 16);
            end
        end
        tick(1, 1, 0, 0, 0, 0);
        checks++;
        if (cnt_a !== 4'd15 || tc_a !== 1'b1) begin
            errors++; $display("FAIL wrap_down got=%0d/%b exp=15/1", cnt_a, tc_a);
        end
        tick(1, 1, 0, 0, 0, 0);
        checks++;
        if (cnt_a !== 4'd14 || tc_a !== 1'b0) begin
            errors++; $display("FAIL wrap_down2 got=%0d/%b exp=14/0", cnt_a, tc_a);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_c [4];
        logic       exp_t [4];
        exp_c = '{4'd8, 4'd9, 4'd9, 4'd9};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
        tick(1, 0, 0, 0, 1, 4'd7);
        checks++;
        if (cnt_b !== 4'd7) begin errors++; $display("FAIL sat_load got=%0d exp=7", cnt_b); end
        for (int k = 0; k < 4; k++) begin
            tick(1, 1, 1, 0, 0, 0);
            checks++;
            if (cnt_b !== exp_c[k] || tc_b !== exp_t[k] || max_b !== (exp_c[k] == 4'd9)) begin
                errors++;
                $display("FAIL sat_up step=%0d got=%0d/%b/%b exp=%0d/%b/%b",
                         k, cnt_b, tc_b, max_b, exp_c[k], exp_t[k], exp_c[k] == 4'd9);
            end
        end
        tick(1, 1, 0, 0, 0, 0);
        checks++;
        if (cnt_b !== 4'd8 || tc_b !== 1'b0) begin
            errors++; $display("FAIL sat_down got=%0d/%b exp=8/0", cnt_b, tc_b);
        end
    endtask

    task automatic test_load();
        tick(1, 0, 0, 0, 1, 4'd13);
        checks++;
        if (cnt_c !== 4'd9 || cnt_b !== 4'd9 || cnt_a !== 4'd13) begin
            errors++; $display("FAIL load_clamp got=%0d/%0d/%0d exp=9/9/13", cnt_c, cnt_b, cnt_a);
        end
        tick(1, 0, 0, 1, 1, 4'd13);
        checks++;
        if (cnt_c !== 4'd3 || cnt_b !== 4'd0 || cnt_a !== 4'd0) begin
            errors++; $display("FAIL load_clear got=%0d/%0d/%0d exp=3/0/0", cnt_c, cnt_b, cnt_a);
        end
        tick(1, 1, 1, 0, 1, 4'd5);
        checks++;
        if (cnt_a !== 4'd5 || cnt_c !== 4'd5 || tc_a !== 1'b0) begin
            errors++; $display("FAIL load_en got=%0d/%0d/%b exp=5/5/0", cnt_a, cnt_c, tc_a);
        end
    endtask

    task automatic test_hold();
        for (int k = 0; k < 5; k++) begin
            tick(1, 0, k[0], 0, 0, 0);
            checks++;
            if (cnt_a !== 4'd5 || cnt_b !== 4'd5 || tc_a !== 1'b0) begin
                errors++; $display("FAIL hold step=%0d got=%0d/%0d/%b exp=5/5/0", k, cnt_a, cnt_b, tc_a);
            end
        end
        tick(1, 0, 0, 0, 1, 4'd0);
        tick(1, 1, 0, 0, 0, 0);
        checks++;
        if (cnt_c !== 4'd9 || tc_c !== 1'b1) begin
            errors++; $display("FAIL down_wrap9 got=%0d/%b exp=9/1", cnt_c, tc_c);
        end
        checks++;
        if (cnt_b !== 4'd0 || tc_b !== 1'b1) begin
            errors++; $display("FAIL down_sat0 got=%0d/%b exp=0/1", cnt_b, tc_b);
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (tc_c !== 1'b0 || cnt_c !== 4'd9) begin
            errors++; $display("FAIL tc_single got=%0d/%b exp=9/0", cnt_c, tc_c);
        end
    endtask

    task automatic test_random();
        tick(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 10000; n++) begin
            tick(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), 4'($urandom));
            for (int i = 0; i < 3; i++) begin
                logic [2:0] exp_f;
                exp_f = {mtc[i] == 1, mc[i] == MMAX[i], mc[i] == 0};
                checks++;
                if (dut_cnt(i) != mc[i] || dut_flags(i) !== exp_f) begin
                    errors++;
                    $display("FAIL random cyc=%0d dut=%0d got cnt=%0d flags=%b exp cnt=%0d flags=%b",
                             n, i, dut_cnt(i), dut_flags(i), mc[i], exp_f);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_wrap();
        test_saturate();
        test_load();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
